tex_sat_pipe: RTL
=================

Name: tex_sat_pipe

Overview:
Multi-lane, pipelined saturation unit for the texture path. It converts wide signed intermediates, such as filter accumulators and address offsets, into narrow texel or coordinate fields. Each request selects a clamp mode: unsigned saturate, signed saturate or wrap. The unit reports which lanes clipped and keeps a sticky event counter for perf and debug. It sits between the texture filter or address stage and the format/writeback stage, with a valid/ready handshake on both sides.

Parameters:
NUM_LANES, 4, number of independent lanes per request
IN_W, 10, input width per lane; signed two's complement
OUT_W, 8, output width per lane; static assert (OUT_W+1) < IN_W
TAG_W, 4, width of the opaque request tag carried alongside the data
SAT_CNT_W, 16, width of the sticky saturation-event counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (0 = in reset)
valid_in  in  1  request valid
ready_in  out  1  unit can accept a request this cycle
mode_in  in  2  0=unsigned sat, 1=signed sat, 2=wrap, 3=reserved (behaves as wrap)
tag_in  in  TAG_W  opaque tag, returned unchanged
data_in  in  NUM_LANES*IN_W  lane i occupies bits [i*IN_W +: IN_W]
valid_out  out  1  result valid
ready_out  in  1  downstream accepts the result
tag_out  out  TAG_W  tag of the result
data_out  out  NUM_LANES*OUT_W  lane i occupies bits [i*OUT_W +: OUT_W]
sat_mask  out  NUM_LANES  bit i = lane i was clipped
sat_count  out  SAT_CNT_W  number of saturating results delivered
sat_clear  in  1  synchronous clear of sat_count

Behaviour:
- Reset (asynchronous, takes effect immediately): valid_out=0, sat_count=0, sat_mask=0, data_out=0, tag_out=0, both stage valids=0, ready_in=1 once reset releases.
- Pipeline has two stages. Latency is exactly 2 cycles from input handshake to valid_out with ready_out held high. Throughput is one request per cycle.
- Global advance: enable = ~valid_out | ready_out, and ready_in = enable. Both stages shift together only when enable=1. This is a stall pipeline, not skid buffered.
- A stalled result holds data_out, tag_out and sat_mask stable until its handshake. No drops and no duplicates; ordering is strictly FIFO.
- Stage 1 registers the following per lane: sign bit, high-part-nonzero flag (bits [IN_W-2:OUT_W]), high-part-not-all-ones flag, low OUT_W bits, mode and tag.
- Stage 2 selects the result per lane:
  - Mode 0: negative gives 0 (clip). A positive value above 2^OUT_W-1 gives all ones (clip). Otherwise the low bits pass through.
  - Mode 1: a value below -2^(OUT_W-1) gives 1 followed by zeros (clip). A value above 2^(OUT_W-1)-1 gives 0 followed by ones (clip). Otherwise the low bits pass through.
  - Mode 2 and mode 3: low OUT_W bits, never a clip.
- sat_mask is registered with data_out. A lane whose value equals the exact boundary (255, -128, 127, 0) is not a clip.
- sat_count:
  - Increments by 1 on each output handshake (valid_out & ready_out) where |sat_mask=1.
  - Saturates at all ones and does not wrap.
  - When sat_clear fires in the same cycle as a counted handshake, the counter ends at 1 (clear first, then count).
  - sat_clear alone sets the counter to 0.
- valid_in while ready_in=0 is ignored. The upstream must hold the request, and the unit samples nothing in that cycle.
- Reset asserted mid-stream discards all in-flight requests with no output.

Decomposition:
- The shared package tex_sat_pkg holds the mode enum (TEX_SAT_UNSIGNED, TEX_SAT_SIGNED, TEX_SAT_WRAP, TEX_SAT_RSVD) and the mode width constant.
- The sub-module tex_sat_lane holds the per-lane stage-2 combinational select and clip detection. It takes as inputs the stage-1 flags, low bits and mode, and produces the result and the clip bit. It is instantiated NUM_LANES times.
- Pipeline registers, handshake and counter live in the top module.

Test Plan (IN_W=10, OUT_W=8, NUM_LANES=4):
- Unsigned: mode 0, lanes {-5 (0x3FB), 0, 200, 300}, ready_out=1 -> 2 cycles later data_out {0x00, 0x00, 0xC8, 0xFF}, sat_mask 4'b1001, tag echoed.
- Signed: mode 1, lanes {-200, -128, 127, 130} -> {0x80, 0x80, 0x7F, 0x7F}, sat_mask 4'b1001. Mode 0 boundary with lane 255 -> 0xFF, mask bit 0.
- Wrap/reserved: mode 2 and mode 3, lanes {300, -1, 256, 44} -> {0x2C, 0xFF, 0x00, 0x2C}, sat_mask 0, sat_count unchanged.
- Backpressure: 3 back-to-back requests with ready_out low for 5 cycles -> ready_in drops once valid_out=1. Outputs stay stable while stalled. After release all 3 results appear in order, once each. Then 1 request/cycle with ready_out high yields 1 result/cycle.
- Counter: SAT_CNT_W=2, 5 saturating handshakes -> sat_count=3 held. Then sat_clear together with a saturating handshake -> 1. sat_clear alone -> 0. A stalled saturating result is not counted until its handshake.
- Reset: pull reset low while valid_out=1 and stage 1 is full -> valid_out=0 and sat_count=0 immediately (asynchronously). After release, no stale result is emitted.

Source files
------------

// File: rtl/tex_sat_pkg.sv
// Shared types for the texture saturation pipe: clamp-mode encoding.
package tex_sat_pkg;

    localparam int TEX_SAT_MODE_W = 2;

    typedef enum logic [TEX_SAT_MODE_W-1:0] {
        TEX_SAT_UNSIGNED = 2'd0,
        TEX_SAT_SIGNED   = 2'd1,
        TEX_SAT_WRAP     = 2'd2,
        TEX_SAT_RSVD     = 2'd3
    } tex_sat_mode_e;

endpackage

// File: rtl/tex_sat_lane.sv
// One lane of the second stage: picks the clamped result from the flags
// precomputed in stage 1 and reports whether the lane clipped.
module tex_sat_lane
    import tex_sat_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic             sign,
    input  logic             hi_nz,
    input  logic             hi_n1,
    input  logic [OUT_W-1:0] lo,
    input  tex_sat_mode_e    mode,
    output logic [OUT_W-1:0] res,
    output logic             clip
);

    // Signed range holds only when every bit above lo[MSB] equals lo[MSB];
    // the stage-1 flags cover the bits above the low field.
    always_comb begin
        res  = lo;
        clip = 1'b0;
        case (mode)
            TEX_SAT_UNSIGNED: begin
                if (sign) begin
                    res  = '0;
                    clip = 1'b1;
                end else if (hi_nz) begin
                    res  = '1;
                    clip = 1'b1;
                end
            end
            TEX_SAT_SIGNED: begin
                if (sign && (hi_n1 || !lo[OUT_W-1])) begin
                    res  = {1'b1, {(OUT_W-1){1'b0}}};
                    clip = 1'b1;
                end else if (!sign && (hi_nz || lo[OUT_W-1])) begin
                    res  = {1'b0, {(OUT_W-1){1'b1}}};
                    clip = 1'b1;
                end
            end
            default: ;  // wrap and reserved keep the low bits, never clip
        endcase
    end

endmodule

// File: rtl/tex_sat_pipe.sv
// Two-stage stall pipeline that saturates NUM_LANES wide signed values to
// OUT_W bits, reports per-lane clipping and counts saturating results.
module tex_sat_pipe
    import tex_sat_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int IN_W      = 10,
    parameter int OUT_W     = 8,
    parameter int TAG_W     = 4,
    parameter int SAT_CNT_W = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           valid_in,
    output logic                           ready_in,
    input  logic [TEX_SAT_MODE_W-1:0]      mode_in,
    input  logic [TAG_W-1:0]               tag_in,
    input  logic [NUM_LANES*IN_W-1:0]      data_in,
    output logic                           valid_out,
    input  logic                           ready_out,
    output logic [TAG_W-1:0]               tag_out,
    output logic [NUM_LANES*OUT_W-1:0]     data_out,
    output logic [NUM_LANES-1:0]           sat_mask,
    output logic [SAT_CNT_W-1:0]           sat_count,
    input  logic                           sat_clear
);

    localparam int STAGES = 2;

    generate
        if ((OUT_W + 1) >= IN_W) begin : g_bad_widths
            $error("tex_sat_pipe: IN_W must exceed OUT_W+1");
        end
    endgenerate

    logic [STAGES:1]                      vld_pipe;
    logic                                 enable;
    logic                                 out_fire;

    logic [NUM_LANES-1:0][IN_W-1:0]       din;
    logic [NUM_LANES-1:0]                 d_sign, d_hi_nz, d_hi_n1;
    logic [NUM_LANES-1:0][OUT_W-1:0]      d_lo;

    logic [NUM_LANES-1:0]                 s1_sign, s1_hi_nz, s1_hi_n1;
    logic [NUM_LANES-1:0][OUT_W-1:0]      s1_lo;
    tex_sat_mode_e                        s1_mode;
    logic [TAG_W-1:0]                     s1_tag;

    logic [NUM_LANES-1:0][OUT_W-1:0]      res;
    logic [NUM_LANES-1:0]                 clip;
    logic [NUM_LANES-1:0][OUT_W-1:0]      dout_q;

    assign din       = data_in;
    assign enable    = ~vld_pipe[STAGES] | ready_out;
    assign ready_in  = enable;
    assign valid_out = vld_pipe[STAGES];
    assign out_fire  = vld_pipe[STAGES] & ready_out;
    assign data_out  = dout_q;

    // Split each lane into sign, high-part flags and low field for stage 1.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            d_sign[i]  = din[i][IN_W-1];
            d_hi_nz[i] = |din[i][IN_W-2:OUT_W];
            d_hi_n1[i] = ~&din[i][IN_W-2:OUT_W];
            d_lo[i]    = din[i][OUT_W-1:0];
        end
    end

    // Valid shift register; both stages advance together on enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
        end else if (enable) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], valid_in};
        end
    end

    // Stage 1 payload: only loaded on an accepted request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_sign  <= '0;
            s1_hi_nz <= '0;
            s1_hi_n1 <= '0;
            s1_lo    <= '0;
            s1_mode  <= TEX_SAT_UNSIGNED;
            s1_tag   <= '0;
        end else if (enable && valid_in) begin
            s1_sign  <= d_sign;
            s1_hi_nz <= d_hi_nz;
            s1_hi_n1 <= d_hi_n1;
            s1_lo    <= d_lo;
            s1_mode  <= tex_sat_mode_e'(mode_in);
            s1_tag   <= tag_in;
        end
    end

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            tex_sat_lane #(.OUT_W(OUT_W)) u_lane (
                .sign  (s1_sign[g]),
                .hi_nz (s1_hi_nz[g]),
                .hi_n1 (s1_hi_n1[g]),
                .lo    (s1_lo[g]),
                .mode  (s1_mode),
                .res   (res[g]),
                .clip  (clip[g])
            );
        end
    endgenerate

    // Stage 2 payload: held while the output is stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q   <= '0;
            sat_mask <= '0;
            tag_out  <= '0;
        end else if (enable && vld_pipe[1]) begin
            dout_q   <= res;
            sat_mask <= clip;
            tag_out  <= s1_tag;
        end
    end

    // Sticky counter of delivered clipping results; clear wins first, then
    // the same-cycle handshake still counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_count <= '0;
        end else if (sat_clear) begin
            sat_count <= (out_fire && |sat_mask) ? SAT_CNT_W'(1) : '0;
        end else if (out_fire && |sat_mask && !(&sat_count)) begin
            sat_count <= sat_count + SAT_CNT_W'(1);
        end
    end

endmodule
